// File: rtl/rx_block_lock_if.sv
// Header/slip handshake between the RX gearbox and the 64b/66b block-lock FSM.
// The gearbox is the master: it supplies headers and consumes slip and lock.
interface rx_block_lock_if;
  logic       i_valid;
  logic [1:0] i_header;
  logic       o_slip;
  logic       o_block_lock;

  modport master (output i_valid, i_header, input o_slip, o_block_lock);
  modport slave  (input i_valid, i_header, output o_slip, o_block_lock);
endinterface

// File: rtl/rx_block_lock.sv
// 64b/66b block-lock state machine: slips the gearbox until the sync header is
// aligned, then holds lock until too many bad headers land in one test window.
module rx_block_lock #(
  parameter int SH_CNT_MAX   = 64,
  parameter int SH_INVLD_MAX = 16,
  parameter int SLIP_WAIT    = 32
) (
  input  logic           i_rxc,
  input  logic           i_reset,
  rx_block_lock_if.slave bl
);
  localparam int SH_W   = $clog2(SH_CNT_MAX + 1);
  localparam int INV_W  = $clog2(SH_INVLD_MAX + 1);
  localparam int WAIT_W = $clog2(SLIP_WAIT + 1);

  localparam logic [SH_W-1:0]   SH_TC   = SH_W'(SH_CNT_MAX);
  localparam logic [INV_W-1:0]  INV_TC  = INV_W'(SH_INVLD_MAX);
  localparam logic [WAIT_W-1:0] WAIT_TC = WAIT_W'(SLIP_WAIT - 1);

  typedef enum logic {ST_TEST_SH, ST_SLIP_WAIT} state_e;

  state_e            state_q, state_d;
  logic [SH_W-1:0]   sh_cnt_q, sh_cnt_d;
  logic [INV_W-1:0]  sh_invld_cnt_q, sh_invld_cnt_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              slip_q, slip_d;
  logic              lock_q, lock_d;

  logic              hdr_bad;
  logic [SH_W-1:0]   sh_n;
  logic [INV_W-1:0]  invld_m;

  // 01 and 10 are the only legal sync headers; both bits equal means invalid.
  assign hdr_bad = ~(bl.i_header[1] ^ bl.i_header[0]);
  assign sh_n    = sh_cnt_q + SH_W'(1);
  assign invld_m = sh_invld_cnt_q + INV_W'(hdr_bad);

  always_comb begin
    state_d        = state_q;
    sh_cnt_d       = sh_cnt_q;
    sh_invld_cnt_d = sh_invld_cnt_q;
    wait_cnt_d     = wait_cnt_q;
    slip_d         = 1'b0;
    lock_d         = lock_q;
    case (state_q)
      ST_TEST_SH: begin
        if (bl.i_valid) begin
          if (hdr_bad && (!lock_q || invld_m == INV_TC)) begin
            slip_d         = 1'b1;
            lock_d         = 1'b0;
            sh_cnt_d       = '0;
            sh_invld_cnt_d = '0;
            wait_cnt_d     = '0;
            state_d        = ST_SLIP_WAIT;
          end else if (sh_n == SH_TC) begin
            // invld_m < SH_INVLD_MAX is implied here: reaching it slips above.
            if (invld_m == '0) lock_d = 1'b1;
            sh_cnt_d       = '0;
            sh_invld_cnt_d = '0;
          end else begin
            sh_cnt_d       = sh_n;
            sh_invld_cnt_d = invld_m;
          end
        end
      end
      ST_SLIP_WAIT: begin
        if (wait_cnt_q == WAIT_TC) begin
          wait_cnt_d = '0;
          state_d    = ST_TEST_SH;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge i_rxc) begin
    if (i_reset) begin
      state_q        <= ST_TEST_SH;
      sh_cnt_q       <= '0;
      sh_invld_cnt_q <= '0;
      wait_cnt_q     <= '0;
      slip_q         <= 1'b0;
      lock_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      sh_cnt_q       <= sh_cnt_d;
      sh_invld_cnt_q <= sh_invld_cnt_d;
      wait_cnt_q     <= wait_cnt_d;
      slip_q         <= slip_d;
      lock_q         <= lock_d;
    end
  end

  assign bl.o_slip       = slip_q;
  assign bl.o_block_lock = lock_q;
endmodule

// File: tb/tb_rx_block_lock.sv
// Bench for rx_block_lock: a reference model queues the expected slip/lock
// after every edge; a negedge monitor pops and compares. Directed checks on top.
module tb_rx_block_lock;
  localparam int SH_CNT_MAX   = 64;
  localparam int SH_INVLD_MAX = 16;
  localparam int SLIP_WAIT    = 32;

  logic clk;
  logic i_reset;
  rx_block_lock_if bl();

  rx_block_lock #(
    .SH_CNT_MAX(SH_CNT_MAX), .SH_INVLD_MAX(SH_INVLD_MAX), .SLIP_WAIT(SLIP_WAIT)
  ) dut (
    .i_rxc  (clk),
    .i_reset(i_reset),
    .bl     (bl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else n_pass++;
  endtask

  // Reference model of the lock algorithm.
  bit m_wait_st;
  int m_sh, m_inv, m_wait;
  bit m_slip, m_lock;

  task automatic model_step(input logic rst, input logic v, input logic [1:0] h);
    bit bad;
    int n, m;
    bad = (h == 2'b00) || (h == 2'b11);
    if (rst) begin
      m_wait_st = 0; m_sh = 0; m_inv = 0; m_wait = 0; m_slip = 0; m_lock = 0;
      return;
    end
    m_slip = 0;
    if (m_wait_st) begin
      if (m_wait == SLIP_WAIT - 1) begin m_wait = 0; m_wait_st = 0; end
      else m_wait++;
    end else if (v) begin
      n = m_sh + 1;
      m = m_inv + (bad ? 1 : 0);
      if (bad && (!m_lock || m == SH_INVLD_MAX)) begin
        m_slip = 1; m_lock = 0; m_sh = 0; m_inv = 0; m_wait = 0; m_wait_st = 1;
      end else if (n == SH_CNT_MAX && m == 0) begin
        m_lock = 1; m_sh = 0; m_inv = 0;
      end else if (n == SH_CNT_MAX && m < SH_INVLD_MAX) begin
        m_sh = 0; m_inv = 0;
      end else begin
        m_sh = n; m_inv = m;
      end
    end
  endtask

  logic [1:0] sb[$];

  task automatic cycle(input logic rst, input logic v, input logic [1:0] h);
    i_reset     = rst;
    bl.i_valid  = v;
    bl.i_header = h;
    model_step(rst, v, h);
    @(posedge clk);
    sb.push_back({m_slip, m_lock});
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    logic [1:0] exp;
    if (sb.size() > 0) begin
      exp = sb.pop_front();
      chk("sb_slip_lock", {30'd0, bl.o_slip, bl.o_block_lock}, {30'd0, exp});
    end
  end

  function automatic logic [1:0] good_hdr(input int i);
    return i[0] ? 2'b10 : 2'b01;
  endfunction

  task automatic run_good(input int cnt);
    for (int i = 0; i < cnt; i++) cycle(1'b0, 1'b1, good_hdr(i));
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, 2'b00);
    cycle(1'b1, 1'b0, 2'b00);
  endtask

  initial begin
    i_reset     = 1'b1;
    bl.i_valid  = 1'b0;
    bl.i_header = 2'b00;

    // Reset state
    do_reset();
    chk("rst_slip", 32'(bl.o_slip), 32'd0);
    chk("rst_lock", 32'(bl.o_block_lock), 32'd0);

    // Clean lock
    run_good(63);
    chk("clean_lock63", 32'(bl.o_block_lock), 32'd0);
    run_good(1);
    chk("clean_lock64", 32'(bl.o_block_lock), 32'd1);

    // Unlocked slip, ignored headers in the wait, then relock
    do_reset();
    run_good(10);
    cycle(1'b0, 1'b1, 2'b11);
    chk("unl_slip", 32'(bl.o_slip), 32'd1);
    for (int i = 0; i < SLIP_WAIT; i++) cycle(1'b0, 1'b1, 2'b11);
    chk("wait_noslip", 32'(bl.o_slip), 32'd0);
    run_good(64);
    chk("relock", 32'(bl.o_block_lock), 32'd1);

    // Locked tolerance: 15 bad headers spread through one window
    for (int i = 0; i < SH_CNT_MAX; i++)
      cycle(1'b0, 1'b1, (i % 4 == 1 && i < 60) ? 2'b00 : good_hdr(i));
    chk("tol_lock", 32'(bl.o_block_lock), 32'd1);
    run_good(64);
    chk("tol_clean", 32'(bl.o_block_lock), 32'd1);

    // Loss of lock: headers 5..20 invalid
    for (int i = 1; i <= 20; i++) begin
      cycle(1'b0, 1'b1, (i >= 5) ? 2'b11 : good_hdr(i));
      if (i == 19) chk("loss_hold19", 32'(bl.o_block_lock), 32'd1);
    end
    chk("loss_slip", 32'(bl.o_slip), 32'd1);
    chk("loss_lock", 32'(bl.o_block_lock), 32'd0);
    for (int i = 0; i < SLIP_WAIT; i++) cycle(1'b0, 1'b0, 2'b00);

    // Gapped valid: bad headers only while i_valid=0
    for (int i = 0; i < 2 * SH_CNT_MAX; i++) begin
      if (i[0]) cycle(1'b0, 1'b0, 2'b00);
      else      cycle(1'b0, 1'b1, good_hdr(i / 2));
      if (i == 2 * SH_CNT_MAX - 3) chk("gap_nolock", 32'(bl.o_block_lock), 32'd0);
    end
    chk("gap_lock", 32'(bl.o_block_lock), 32'd1);

    // Reset during the slip cycle
    do_reset();
    run_good(3);
    cycle(1'b0, 1'b1, 2'b00);
    chk("mid_slip", 32'(bl.o_slip), 32'd1);
    cycle(1'b1, 1'b1, 2'b00);
    chk("rst_slip_cyc", {30'd0, bl.o_slip, bl.o_block_lock}, 32'd0);
    run_good(64);
    chk("rst_slip_lock", 32'(bl.o_block_lock), 32'd1);

    // Reset mid-wait
    do_reset();
    cycle(1'b0, 1'b1, 2'b11);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 2'b00);
    cycle(1'b1, 1'b0, 2'b00);
    chk("rst_wait_out", {30'd0, bl.o_slip, bl.o_block_lock}, 32'd0);
    run_good(64);
    chk("rst_wait_lock", 32'(bl.o_block_lock), 32'd1);

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      logic v;
      logic [1:0] h;
      v = ($urandom_range(0, 4) != 0);
      h = ($urandom_range(0, 39) == 0) ? 2'(($urandom_range(0, 1)) * 3) : good_hdr(i);
      cycle(($urandom_range(0, 499) == 0), v, h);
    end

    @(negedge clk);
    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
